// File: rtl/pc_gen_reg_if.sv
// Fetch-control bus for the PC generator.
// The master side (fetch control) drives stall, redirect and halt/resume.
// The slave side (pc_gen_reg) returns the current PC and its status.
interface pc_gen_reg_if #(
  parameter int WIDTH = 16
);

  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             pc_valid;
  logic             halted;

  modport master (
    output stall, redirect_valid, redirect_target, halt_req, resume,
    input  pc, pc_plus_inc, pc_valid, halted
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, halt_req, resume,
    output pc, pc_plus_inc, pc_valid, halted
  );

endinterface

// File: rtl/pc_gen_reg.sv
// Program-counter generator and register for the fetch stage.
// The PC advances by INC each cycle, holds on stall and loads a branch or jump
// target on redirect. A two-state RUN/HALTED FSM freezes the PC on halt_req and
// restarts it at pc+INC on resume. Wrap-around at 2^WIDTH is silent.
module pc_gen_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INC       = WIDTH'(2)
) (
  input  logic        clk,
  input  logic        rst,
  pc_gen_reg_if.slave bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  logic             r_halted;
  logic [WIDTH-1:0] w_pc_plus_inc;

  // Sequential step; the sum is truncated to WIDTH bits, so it wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] pc_in);
    f_step = pc_in + INC;
  endfunction

  assign w_pc_plus_inc = f_step(r_pc);

  // RUN/HALTED FSM with the PC register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b1;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.redirect_valid) begin
            // A redirect wins over both stall and halt_req.
            r_pc       <= bus.redirect_target;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end else if (bus.stall) begin
            // Hold. A pending halt_req is seen again once the stall clears.
            r_pc       <= r_pc;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end else if (bus.halt_req) begin
            // The PC stays on the HLT instruction while halted.
            r_state    <= ST_HALTED;
            r_pc       <= r_pc;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b1;
          end else begin
            r_pc       <= w_pc_plus_inc;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (bus.resume) begin
            // Execution continues after the HLT. halt_req is not looked at here.
            r_state    <= ST_RUN;
            r_pc       <= w_pc_plus_inc;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end else begin
            r_pc       <= r_pc;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_pc       <= RESET_VEC;
          r_pc_valid <= 1'b1;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_plus_inc = w_pc_plus_inc;
  assign bus.pc_valid    = r_pc_valid;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_pc_gen_reg.sv
// Bench for pc_gen_reg. Two instances are built: 16-bit/INC=2 and 12-bit/INC=4
// with reset vector 0x100. Directed scenarios come first, then a random run.
// Every result is compared against a behavioural model of the PC rules.
module tb_pc_gen_reg;

  localparam int W0 = 16, INC0 = 2, RV0 = 0;
  localparam int W1 = 12, INC1 = 4, RV1 = 'h100;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  // Stimulus registers, driven onto the interfaces.
  logic        d0_rv, d0_st, d0_h, d0_rs;
  logic [15:0] d0_tgt;
  logic        d1_rv, d1_st, d1_h, d1_rs;
  logic [11:0] d1_tgt;

  pc_gen_reg_if #(.WIDTH(W0)) if0();
  pc_gen_reg_if #(.WIDTH(W1)) if1();

  assign if0.redirect_valid  = d0_rv;
  assign if0.redirect_target = d0_tgt;
  assign if0.stall           = d0_st;
  assign if0.halt_req        = d0_h;
  assign if0.resume          = d0_rs;
  assign if1.redirect_valid  = d1_rv;
  assign if1.redirect_target = d1_tgt;
  assign if1.stall           = d1_st;
  assign if1.halt_req        = d1_h;
  assign if1.resume          = d1_rs;

  pc_gen_reg #(.WIDTH(W0), .RESET_VEC(16'h0000), .INC(16'h0002))
    dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  pc_gen_reg #(.WIDTH(W1), .RESET_VEC(12'h100), .INC(12'h004))
    dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: PC as a plain integer and a halted flag.
  int m0_pc, m1_pc;
  bit m0_h, m1_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the PC rules, in plain integer arithmetic.
  task automatic model_edge(input int w, input int inc, input int rv, input bit r,
                            input bit v, input int tgt, input bit st, input bit h,
                            input bit rs, inout int pc, inout bit hal);
    if (r) begin
      pc  = rv;
      hal = 1'b0;
    end else if (!hal) begin
      if (v) pc = tgt;
      else if (!st) begin
        if (h) hal = 1'b1;
        else   pc = (pc + inc) % (1 << w);
      end
    end else if (rs) begin
      pc  = (pc + inc) % (1 << w);
      hal = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(W0, INC0, RV0, rst0, d0_rv, int'(d0_tgt), d0_st, d0_h, d0_rs, m0_pc, m0_h);
    model_edge(W1, INC1, RV1, rst1, d1_rv, int'(d1_tgt), d1_st, d1_h, d1_rs, m1_pc, m1_h);
  endtask

  task automatic check0(input string tag);
    chk({tag, ".pc"},  32'(if0.pc),          32'(m0_pc));
    chk({tag, ".ppi"}, 32'(if0.pc_plus_inc), 32'((m0_pc + INC0) % (1 << W0)));
    chk({tag, ".vld"}, 32'(if0.pc_valid),    32'(!m0_h));
    chk({tag, ".hlt"}, 32'(if0.halted),      32'(m0_h));
  endtask

  task automatic check1(input string tag);
    chk({tag, ".pc"},  32'(if1.pc),          32'(m1_pc));
    chk({tag, ".ppi"}, 32'(if1.pc_plus_inc), 32'((m1_pc + INC1) % (1 << W1)));
    chk({tag, ".vld"}, 32'(if1.pc_valid),    32'(!m1_h));
    chk({tag, ".hlt"}, 32'(if1.halted),      32'(m1_h));
  endtask

  task automatic drv0(input bit v, input logic [15:0] tgt, input bit st, input bit h, input bit rs);
    d0_rv = v; d0_tgt = tgt; d0_st = st; d0_h = h; d0_rs = rs;
  endtask

  task automatic drv1(input bit v, input logic [11:0] tgt, input bit st, input bit h, input bit rs);
    d1_rv = v; d1_tgt = tgt; d1_st = st; d1_h = h; d1_rs = rs;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    drv0(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    drv1(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    m0_pc = RV0; m0_h = 1'b0;
    m1_pc = RV1; m1_h = 1'b0;

    // Reset values are present before any clock edge.
    #1;
    check0("rst_noclk");
    chk("rst_pc_const", 32'(if0.pc), 32'h0);
    tick(); tick();
    rst0 = 1'b0;

    // Sequential run from the reset vector.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check0("seq");
      chk("seq_const", 32'(if0.pc), 32'(2 * k));
    end

    // Wrap-around through 0xFFFE.
    drv0(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0); tick(); check0("wrap_ld");
    drv0(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);    tick(); check0("wrap");
    chk("wrap_pc", 32'(if0.pc), 32'h0);
    chk("wrap_ppi", 32'(if0.pc_plus_inc), 32'h2);

    // Stall holds the PC, and a redirect overrides the stall.
    drv0(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0); tick(); check0("stl_ld");
    drv0(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);    tick(); check0("stall1");
    tick(); check0("stall2");
    chk("stall_pc", 32'(if0.pc), 32'h10);
    drv0(1'b1, 16'h0A40, 1'b1, 1'b0, 1'b0); tick(); check0("stl_redir");
    chk("stl_redir_pc", 32'(if0.pc), 32'hA40);

    // Halt, then resume. A redirect while halted is ignored.
    drv0(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0); tick(); check0("h_ld");
    drv0(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);    tick(); check0("halt");
    chk("halt_flag", 32'(if0.halted), 32'h1);
    drv0(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); tick(); check0("h_redir");
    chk("h_redir_pc", 32'(if0.pc), 32'h20);
    drv0(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);    tick(); check0("resume");
    chk("resume_pc", 32'(if0.pc), 32'h22);

    // halt_req during a stall is ignored and is taken once the stall clears.
    drv0(1'b0, 16'h0, 1'b1, 1'b1, 1'b0); tick(); check0("h_stall");
    chk("h_stall_hlt", 32'(if0.halted), 32'h0);
    drv0(1'b0, 16'h0, 1'b0, 1'b1, 1'b0); tick(); check0("h_after");
    chk("h_after_hlt", 32'(if0.halted), 32'h1);
    // resume together with halt_req leaves HALTED.
    drv0(1'b0, 16'h0, 1'b0, 1'b1, 1'b1); tick(); check0("rs_and_h");
    drv0(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Second instance: wrap, then reset while halted.
    rst1 = 1'b0;
    tick(); check1("w12_run");
    chk("w12_run_pc", 32'(if1.pc), 32'h104);
    drv1(1'b1, 12'hFFC, 1'b0, 1'b0, 1'b0); tick(); check1("w12_ld");
    drv1(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);   tick(); check1("w12_wrap");
    chk("w12_wrap_pc", 32'(if1.pc), 32'h0);
    drv1(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);   tick(); check1("w12_halt");
    drv1(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst1 = 1'b1;
    #1;
    m1_pc = RV1; m1_h = 1'b0;
    check1("w12_arst");
    chk("w12_arst_pc", 32'(if1.pc), 32'h100);
    tick();
    rst1 = 1'b0;
    tick(); check1("w12_rel");
    chk("w12_rel_pc", 32'(if1.pc), 32'h104);

    // Random run on both instances, with an occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      drv0(($urandom % 6) == 0, 16'($urandom), ($urandom % 4) == 0,
           ($urandom % 6) == 0, ($urandom % 3) == 0);
      drv1(($urandom % 6) == 0, 12'($urandom), ($urandom % 4) == 0,
           ($urandom % 6) == 0, ($urandom % 3) == 0);
      if ((i % 97) == 50) begin
        #2;
        rst0 = 1'b1;
        #1;
        m0_pc = RV0; m0_h = 1'b0;
        check0("rnd_arst");
        tick();
        check0("rnd_rst_edge");
        rst0 = 1'b0;
      end else begin
        tick();
        check0("rnd0");
        check1("rnd1");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pc_gen_reg.md
Name: pc_gen_reg

Overview:
- Parametrised program-counter generator and register for the fetch stage.
- Holds the current PC and advances it by a configurable increment each cycle.
- Supports pipeline stall, branch/jump redirect and halt/resume.
- Generalises the fixed 16-bit PC register to any width, reset vector and step, and adds next-PC selection plus a two-state halt FSM.

Parameters:
- WIDTH, 16, PC width in bits (legal range 4..32).
- RESET_VEC, 0, PC value loaded on reset; a WIDTH-bit constant.
- INC, 2, sequential step added to the PC; must be a nonzero value below 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- stall  input  1  hold PC this cycle (fetch blocked downstream).
- redirect_valid  input  1  load redirect_target as next PC.
- redirect_target  input  WIDTH  branch/jump destination.
- halt_req  input  1  HLT decoded; freeze PC and enter HALTED.
- resume  input  1  leave HALTED; continue at pc+INC.
- pc  output  WIDTH  current PC (registered).
- pc_plus_inc  output  WIDTH  combinational pc+INC, modulo 2^WIDTH.
- pc_valid  output  1  pc is a live fetch address (registered).
- halted  output  1  FSM is in HALTED (registered).

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - pc=RESET_VEC, state=RUN, pc_valid=1, halted=0.
  - Deassertion is synchronised externally; the first rising edge after deassertion applies the normal rules.
- FSM states: RUN, HALTED. The halted output is registered and equals (state==HALTED).
- RUN, per rising edge, priority highest first:
  1. redirect_valid=1: pc<=redirect_target; stay RUN. Overrides stall and halt_req.
  2. stall=1: pc holds; stay RUN; halt_req is ignored this cycle. The source must hold halt_req until stall clears.
  3. halt_req=1: pc holds (points at the HLT); next state HALTED; pc_valid<=0.
  4. Otherwise: pc<=pc_plus_inc.
- In RUN, resume is ignored.
- HALTED, per rising edge:
  - resume=1: pc<=pc_plus_inc; next state RUN; pc_valid<=1.
  - Otherwise pc holds and pc_valid stays 0.
  - redirect_valid, stall and halt_req are ignored.
  - resume and halt_req together resumes; halt_req is not re-evaluated until the next RUN cycle.
- Arithmetic:
  - pc_plus_inc = (pc+INC) truncated to WIDTH bits. Wrap-around is silent: no flag, no trap.
  - redirect_target is taken as-is, with no alignment masking.
- Latency:
  - A redirect or resume presented in cycle N is visible on pc after edge N+1.
  - pc_plus_inc follows pc combinationally, with zero latency.
- Reset mid-operation:
  - Asserting rst in any state, including HALTED or during a stall, immediately forces reset values.
  - A redirect presented in the same cycle is discarded.
- No X propagation: every register has a defined reset value, and all next-state logic is fully specified for every input combination.

Test Plan:
- Reset and sequential run: WIDTH=16, RESET_VEC=0x0000, INC=2; assert rst mid-cycle, then release and run 4 edges with no control inputs.
  - During rst: pc=0x0000 immediately, pc_valid=1, halted=0.
  - After 4 edges: pc steps 0x0002, 0x0004, 0x0006, 0x0008.
- Wrap-around: set pc to 0xFFFE via a redirect, then run 1 edge with no control inputs -> pc=0x0000, pc_plus_inc=0x0002.
- Stall vs redirect: at pc=0x0010, assert stall for 2 edges -> pc stays 0x0010. Then assert stall and redirect_valid together with target 0x0A40 -> pc=0x0A40 after that edge.
- Halt/resume:
  - At pc=0x0020, pulse halt_req -> after the edge pc=0x0020, halted=1, pc_valid=0.
  - Assert redirect_valid (target 0x1234) while halted -> pc stays 0x0020.
  - Pulse resume -> pc=0x0022, halted=0, pc_valid=1.
- Halt under stall: with stall=1 and halt_req=1 for 1 edge -> pc unchanged, halted=0. Then stall=0 with halt_req=1 -> halted=1 after the next edge.
- Reset while halted, using the parameter override WIDTH=12, RESET_VEC=0x100, INC=4:
  - Reach HALTED, then assert rst asynchronously -> pc=0x100, halted=0, pc_valid=1 with no clock edge.
  - Release rst and run 1 edge -> pc=0x104.
